// File: rtl/mips_program_loader.sv
// Preload sequencer for MIPS program memory: packs UART bytes MSB-first into
// instruction words, strobes them into memory and releases the CPU on the end marker.
module mips_program_loader #(
  parameter int             LEN               = 32,
  parameter int             NB_BYTE           = 8,
  parameter int             RAM_DEPTH_PROGRAM = 32,
  parameter logic [LEN-1:0] END_MARKER        = 32'hFFFF_FFFF,
  parameter int             TIMEOUT_CYCLES    = 1024
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic [NB_BYTE-1:0] i_rx_data,
  input  logic               i_rx_valid,
  output logic               o_preload_flag,
  output logic [LEN-1:0]     o_preload_address,
  output logic [LEN-1:0]     o_preload_instruction,
  output logic               o_cpu_run,
  output logic               o_error,
  output logic               o_frame_err,
  output logic [LEN-1:0]     o_word_count
);

  localparam int BPW = LEN / NB_BYTE;
  localparam int BCW = (BPW > 1) ? $clog2(BPW) : 1;
  localparam int TW  = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RECV  = 3'd1,
    S_WRITE = 3'd2,
    S_DONE  = 3'd3,
    S_ERROR = 3'd4
  } state_t;

  state_t           r_state,      w_state;
  logic [BCW-1:0]   r_byte_cnt,   w_byte_cnt;
  logic [LEN-1:0]   r_addr,       w_addr;
  logic [TW-1:0]    r_timeout,    w_timeout;
  logic [LEN-1:0]   r_shift,      w_shift;
  logic             r_flag,       w_flag;
  logic [LEN-1:0]   r_paddr,      w_paddr;
  logic [LEN-1:0]   r_instr,      w_instr;
  logic             r_cpu_run,    w_cpu_run;
  logic             r_error,      w_error;
  logic             r_frame_err,  w_frame_err;
  logic [LEN-1:0]   r_word_count, w_word_count;
  logic [LEN-1:0]   w_word;
  logic             w_last;

  assign w_word = {r_shift[LEN-NB_BYTE-1:0], i_rx_data};
  assign w_last = (r_byte_cnt == BCW'(BPW - 1));

  // The byte path stays live in WRITE so a byte arriving during the strobe starts the next word.
  always_comb begin
    w_state      = r_state;
    w_byte_cnt   = r_byte_cnt;
    w_addr       = r_addr;
    w_timeout    = r_timeout;
    w_shift      = r_shift;
    w_flag       = 1'b0;
    w_paddr      = r_paddr;
    w_instr      = r_instr;
    w_cpu_run    = r_cpu_run;
    w_error      = r_error;
    w_frame_err  = 1'b0;
    w_word_count = r_word_count;
    case (r_state)
      S_IDLE, S_DONE, S_ERROR: begin
        if (i_start) begin
          w_state      = S_RECV;
          w_byte_cnt   = '0;
          w_addr       = '0;
          w_timeout    = '0;
          w_shift      = '0;
          w_word_count = '0;
          w_error      = 1'b0;
          w_cpu_run    = 1'b0;
        end else begin
          w_state = r_state;
        end
      end
      S_RECV, S_WRITE: begin
        if (r_state == S_WRITE) begin
          w_state      = S_RECV;
          w_addr       = r_addr + LEN'(1);
          w_word_count = r_word_count + LEN'(1);
        end else begin
          w_state = S_RECV;
        end
        if (i_rx_valid) begin
          w_shift   = w_word;
          w_timeout = '0;
          if (w_last) begin
            w_byte_cnt = '0;
            if (w_word == END_MARKER) begin
              w_state   = S_DONE;
              w_cpu_run = 1'b1;
            end else if (r_addr == LEN'(RAM_DEPTH_PROGRAM)) begin
              w_state = S_ERROR;
              w_error = 1'b1;
            end else begin
              w_state = S_WRITE;
              w_flag  = 1'b1;
              w_paddr = r_addr;
              w_instr = w_word;
            end
          end else begin
            w_byte_cnt = r_byte_cnt + BCW'(1);
          end
        end else if (r_byte_cnt != '0) begin
          if (r_timeout == TW'(TIMEOUT_CYCLES - 1)) begin
            w_byte_cnt  = '0;
            w_timeout   = '0;
            w_frame_err = 1'b1;
          end else begin
            w_timeout = r_timeout + TW'(1);
          end
        end else begin
          w_timeout = '0;
        end
      end
      default: begin
        w_state = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any session including a pending write.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_byte_cnt   <= '0;
      r_addr       <= '0;
      r_timeout    <= '0;
      r_shift      <= '0;
      r_flag       <= 1'b0;
      r_paddr      <= '0;
      r_instr      <= '0;
      r_cpu_run    <= 1'b0;
      r_error      <= 1'b0;
      r_frame_err  <= 1'b0;
      r_word_count <= '0;
    end else begin
      r_state      <= w_state;
      r_byte_cnt   <= w_byte_cnt;
      r_addr       <= w_addr;
      r_timeout    <= w_timeout;
      r_shift      <= w_shift;
      r_flag       <= w_flag;
      r_paddr      <= w_paddr;
      r_instr      <= w_instr;
      r_cpu_run    <= w_cpu_run;
      r_error      <= w_error;
      r_frame_err  <= w_frame_err;
      r_word_count <= w_word_count;
    end
  end

  assign o_preload_flag        = r_flag;
  assign o_preload_address     = r_paddr;
  assign o_preload_instruction = r_instr;
  assign o_cpu_run             = r_cpu_run;
  assign o_error               = r_error;
  assign o_frame_err           = r_frame_err;
  assign o_word_count          = r_word_count;

endmodule

// File: tb/tb_mips_program_loader.sv
// Self-checking bench for mips_program_loader: table-driven sessions, randomized
// programs against a word-level reference model, and hand-written corner sequences.
module tb_mips_program_loader;

  localparam int          LEN   = 32;
  localparam int          DEPTH = 32;
  localparam int          TO    = 1024;
  localparam logic [31:0] MARK  = 32'hFFFF_FFFF;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_start = 1'b0;
  logic [7:0]  i_rx_data = 8'h00;
  logic        i_rx_valid = 1'b0;
  logic        o_preload_flag;
  logic [31:0] o_preload_address;
  logic [31:0] o_preload_instruction;
  logic        o_cpu_run;
  logic        o_error;
  logic        o_frame_err;
  logic [31:0] o_word_count;

  mips_program_loader #(
    .LEN(LEN), .NB_BYTE(8), .RAM_DEPTH_PROGRAM(DEPTH),
    .END_MARKER(MARK), .TIMEOUT_CYCLES(TO)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start),
    .i_rx_data(i_rx_data), .i_rx_valid(i_rx_valid),
    .o_preload_flag(o_preload_flag), .o_preload_address(o_preload_address),
    .o_preload_instruction(o_preload_instruction), .o_cpu_run(o_cpu_run),
    .o_error(o_error), .o_frame_err(o_frame_err), .o_word_count(o_word_count)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    int n_words;
    bit data_is_addr;
    int gap;
    int exp_writes;
    bit exp_run;
    bit exp_err;
  } vec_t;

  int          n_pass  = 0;
  int          n_total = 0;
  int          fe_cnt  = 0;
  logic [63:0] cap_q[$];
  logic [31:0] prog_q[$];
  logic [31:0] exp_q[$];
  bit          exp_run;
  bit          exp_err;
  vec_t        vecs[6];

  // Strobe and frame-error monitor, sampled on the inactive edge.
  always @(negedge i_clk) begin
    if (o_preload_flag) cap_q.push_back({o_preload_address, o_preload_instruction});
    if (o_frame_err) fe_cnt = fe_cnt + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic start_session();
    @(negedge i_clk);
    cap_q.delete();
    fe_cnt = 0;
    i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    i_rx_valid = 1'b1;
    i_rx_data  = b;
    @(negedge i_clk);
    i_rx_valid = 1'b0;
    i_rx_data  = 8'h00;
    repeat (gap) @(negedge i_clk);
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    for (int k = 3; k >= 0; k--) begin
      logic [31:0] tmp;
      tmp = w >> (8 * k);
      send_byte(tmp[7:0], (gap < 0) ? int'($urandom_range(0, 2)) : gap);
    end
  endtask

  task automatic send_prog(input int gap);
    foreach (prog_q[i]) send_word(prog_q[i], gap);
    repeat (6) @(negedge i_clk);
    #1;
  endtask

  // Reference: words are written in order until the marker; one past the depth overflows.
  task automatic model_session();
    exp_q.delete();
    exp_run = 1'b0;
    exp_err = 1'b0;
    foreach (prog_q[i]) begin
      if (exp_run || exp_err) break;
      if (prog_q[i] == MARK) exp_run = 1'b1;
      else if (exp_q.size() == DEPTH) exp_err = 1'b1;
      else exp_q.push_back(prog_q[i]);
    end
  endtask

  task automatic check_session(input string name, input int n, input bit run, input bit err);
    check({name, ".strobes"}, cap_q.size(), n);
    for (int i = 0; i < cap_q.size() && i < exp_q.size(); i++) begin
      check({name, ".addr"}, cap_q[i][63:32], i);
      check({name, ".data"}, cap_q[i][31:0], exp_q[i]);
    end
    check({name, ".run"}, {31'd0, o_cpu_run}, {31'd0, run});
    check({name, ".err"}, {31'd0, o_error}, {31'd0, err});
    check({name, ".wcount"}, o_word_count, n);
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    w = $urandom;
    if (w == MARK) w = 32'h0000_0000;
    return w;
  endfunction

  initial begin
    vecs[0] = '{2,  1'b0, 1, 2,  1'b1, 1'b0};
    vecs[1] = '{3,  1'b0, 0, 3,  1'b1, 1'b0};
    vecs[2] = '{32, 1'b1, 0, 32, 1'b1, 1'b0};
    vecs[3] = '{33, 1'b1, 0, 32, 1'b0, 1'b1};
    vecs[4] = '{0,  1'b0, 0, 0,  1'b1, 1'b0};
    vecs[5] = '{5,  1'b0, 3, 5,  1'b1, 1'b0};

    #3;
    check("reset.flag", {31'd0, o_preload_flag}, 32'd0);
    check("reset.addr", o_preload_address, 32'd0);
    check("reset.instr", o_preload_instruction, 32'd0);
    check("reset.run", {31'd0, o_cpu_run}, 32'd0);
    check("reset.err", {31'd0, o_error}, 32'd0);
    check("reset.wcount", o_word_count, 32'd0);
    @(negedge i_clk);
    i_rst = 1'b0;

    // Directed program from the bring-up example.
    prog_q = '{32'h2001_0005, 32'h2002_0007, MARK};
    model_session();
    start_session();
    send_prog(1);
    check_session("basic", 2, 1'b1, 1'b0);
    check("basic.w0", cap_q.size() > 0 ? cap_q[0] : 64'd0, {32'd0, 32'h2001_0005});

    foreach (vecs[v]) begin
      prog_q.delete();
      for (int i = 0; i < vecs[v].n_words; i++)
        prog_q.push_back(vecs[v].data_is_addr ? i : rand_word());
      prog_q.push_back(MARK);
      model_session();
      start_session();
      send_prog(vecs[v].gap);
      check_session($sformatf("vec%0d", v), vecs[v].exp_writes, vecs[v].exp_run, vecs[v].exp_err);
    end

    // Restart from DONE: run drops one cycle after the start pulse.
    prog_q = '{32'h1234_5678, MARK};
    model_session();
    start_session();
    #1;
    check("restart.run_drop", {31'd0, o_cpu_run}, 32'd0);
    send_prog(0);
    check_session("restart", 1, 1'b1, 1'b0);

    for (int r = 0; r < 8; r++) begin
      int n;
      n = $urandom_range(0, 34);
      prog_q.delete();
      for (int i = 0; i < n; i++) prog_q.push_back(rand_word());
      prog_q.push_back(MARK);
      model_session();
      start_session();
      send_prog(-1);
      check_session($sformatf("rand%0d", r), exp_q.size(), exp_run, exp_err);
    end

    // Partial word timeout.
    start_session();
    send_byte(8'hAB, 0);
    send_byte(8'hCD, 0);
    repeat (TO - 1) @(negedge i_clk);
    #1;
    check("timeout.early", fe_cnt, 0);
    repeat (6) @(negedge i_clk);
    #1;
    check("timeout.pulse", fe_cnt, 1);
    check("timeout.nowrite", cap_q.size(), 0);
    prog_q = '{32'h0000_0001, MARK};
    model_session();
    send_prog(0);
    check_session("timeout.after", 1, 1'b1, 1'b0);

    // Asynchronous reset in the middle of a word.
    start_session();
    send_word(32'hCAFE_0001, 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    send_byte(8'h33, 0);
    #2;
    i_rst = 1'b1;
    #1;
    check("arst.addr", o_preload_address, 32'd0);
    check("arst.instr", o_preload_instruction, 32'd0);
    check("arst.wcount", o_word_count, 32'd0);
    check("arst.flag", {31'd0, o_preload_flag}, 32'd0);
    @(negedge i_clk);
    i_rst = 1'b0;
    cap_q.delete();
    prog_q = '{32'h0102_0304, MARK};
    send_prog(0);
    check("arst.ignored", cap_q.size(), 0);
    check("arst.idle_run", {31'd0, o_cpu_run}, 32'd0);
    prog_q = '{32'hBEEF_0042, MARK};
    model_session();
    start_session();
    send_prog(0);
    check_session("arst.after", 1, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mips_program_loader.md
Name: mips_program_loader

Overview:
- Sequences the preload of MIPS program memory before execution.
- Assembles a byte stream (from the UART receiver) into 32-bit instruction words and drives the top-level preload interface (preload flag, address, instruction).
- Detects the end-of-program marker, then asserts the run enable that takes the pipeline out of load mode.
- Sits between the UART RX block and top_mips; replaces bench-driven preloading on hardware.

Parameters:
- LEN, 32, instruction word and preload address width.
- NB_BYTE, 8, width of the incoming data byte.
- RAM_DEPTH_PROGRAM, 32, number of program memory words; maximum number of writes.
- END_MARKER, 32'hFFFFFFFF, word that terminates the load; it is never written to memory.
- TIMEOUT_CYCLES, 1024, idle cycles after which a partial word is discarded.

Ports:
- i_clk  in  1  system clock; all logic on the rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_start  in  1  one-cycle pulse; begins (or restarts) a load session.
- i_rx_data  in  NB_BYTE  received byte.
- i_rx_valid  in  1  i_rx_data valid this cycle; cannot be back-pressured.
- o_preload_flag  out  1  one-cycle write strobe to program memory.
- o_preload_address  out  LEN  word address of the write, zero-extended.
- o_preload_instruction  out  LEN  instruction word being written.
- o_cpu_run  out  1  high = load finished, CPU released to execute.
- o_error  out  1  high = program overflow; sticky until the next i_start.
- o_frame_err  out  1  one-cycle pulse when a partial word times out.
- o_word_count  out  LEN  number of words written in the current session.

Behaviour:
- Reset (async, i_rst=1):
  - state=IDLE.
  - Byte counter, address counter, timeout counter, shift register all 0.
  - Every output 0.
- State IDLE:
  - Outputs idle.
  - i_start=1 -> RECV; clears address counter, byte counter, o_word_count, o_error, o_cpu_run.
  - i_rx_valid is ignored in IDLE, including in the same cycle as i_start.
- State RECV:
  - Each i_rx_valid cycle shifts i_rx_data into the shift register, MSB first (first byte -> bits 31:24), and increments the byte counter (0..3).
  - On the 4th byte, the assembled word W is evaluated in that same cycle:
    - W==END_MARKER -> DONE; no write.
    - Else if address counter==RAM_DEPTH_PROGRAM -> ERROR; no write.
    - Else -> WRITE; W is registered into o_preload_instruction and the address counter into o_preload_address.
    - In all three cases the byte counter returns to 0.
  - i_start in RECV is ignored.
- State WRITE (exactly 1 cycle):
  - o_preload_flag=1 with the registered address and instruction.
  - Address counter += 1; o_word_count += 1.
  - Unconditional return to RECV next cycle.
  - An i_rx_valid byte in WRITE is accepted as byte 0 of the next word; no byte is ever dropped.
- Write latency: o_preload_flag is high the cycle after the 4th byte is sampled.
- o_preload_flag is 0 in every state except WRITE. Address and instruction outputs hold their last values otherwise.
- Timeout:
  - In RECV with byte counter != 0, the timeout counter increments on each cycle without i_rx_valid; any i_rx_valid clears it.
  - Reaching TIMEOUT_CYCLES-1 clears the byte counter and timeout counter and pulses o_frame_err for 1 cycle; state stays RECV.
  - The timeout counter is held at 0 when the byte counter is 0.
- State DONE:
  - o_cpu_run=1, held.
  - i_rx_valid ignored.
  - i_start -> RECV with the same clearing as in IDLE; o_cpu_run drops the next cycle.
- State ERROR:
  - o_error=1, o_cpu_run=0.
  - i_rx_valid ignored.
  - i_start -> RECV (clears o_error).
- Boundaries:
  - Exactly RAM_DEPTH_PROGRAM words followed by END_MARKER -> DONE with no error.
  - A (DEPTH+1)-th non-marker word -> ERROR.
  - Empty program (marker first) -> DONE with o_word_count=0.
  - Reset mid-session aborts immediately; a write in progress is not completed.

Test Plan:
- Reset, i_start, bytes 20 01 00 05 | 20 02 00 07 | FF FF FF FF -> two strobes: addr 0 data 32'h20010005, addr 1 data 32'h20020007; then o_cpu_run=1, o_word_count=2, o_error=0.
- Back-to-back bytes every cycle, 3 words -> no byte lost; the byte arriving during WRITE becomes the MSB of the next word; strobes at addr 0,1,2.
- 32 words (data = address) then marker -> DONE, o_word_count=32. Repeat with a 33rd word -> o_error=1, 32 strobes only, o_cpu_run=0.
- Send 2 bytes, idle TIMEOUT_CYCLES cycles -> one o_frame_err pulse, no write; next 4 bytes 00 00 00 01 -> strobe addr 0 data 32'h00000001.
- Marker as the first word -> DONE, no strobe, o_word_count=0. Then i_start and a new 1-word program -> o_cpu_run drops, then rises again; strobe at addr 0.
- Assert i_rst after the 3rd byte of a word -> all outputs 0 asynchronously, state IDLE; bytes after reset are ignored until i_start.
